// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART transmit arbiter.
//   arb_state_t     : FSM state encoding (IDLE, START, WAIT_DONE)
//   DEFAULT_TIMEOUT : default watchdog limit in clk cycles
//   idx_width()     : width of a requester index (minimum 1 bit)
//   wd_width()      : width of the watchdog counter for a given limit
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 200000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The watchdog counts 0 .. cycles-1, so clog2(cycles) bits suffice.
  function automatic int wd_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester-side and uart_tx-side signals
// of the arbiter.
//   req_valid/req_data  : requester byte offers (requester i at [i*DATA_W +: DATA_W])
//   req_ready/req_done  : one-hot 1-cycle accept / finish pulses
//   start_trigger/tx_data, tx_busy/tx_done : uart_tx side
//   grant_id, arb_busy, timeout_err, state  : status and debug
// Handshake: a requester raises req_valid with req_data and holds both
// until it sees its req_ready bit for one cycle; at that edge the byte is
// latched and req_valid may drop. Dropping req_valid before req_ready
// withdraws the offer. req_done later marks the byte as sent or aborted.
// modport master = arbiter, modport slave = requesters plus uart_tx.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic                      start_trigger;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [IDX_W-1:0]          grant_id;
  logic                      arb_busy;
  logic                      timeout_err;
  arb_state_t                state;

  modport master (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ready, req_done, start_trigger, tx_data,
           grant_id, arb_busy, timeout_err, state
  );

  modport slave (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ready, req_done, start_trigger, tx_data,
           grant_id, arb_busy, timeout_err, state
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority pick.
//   req       : request vector
//   ptr       : index with highest priority this round
//   grant     : one-hot winner (all zero when no request)
//   idx       : winner index
//   any_valid : at least one request present
module rr_pick import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit of
  // rot is then the distance from ptr to the winner.
  assign rot       = NUM_REQ'({req, req} >> ptr);
  assign any_valid = |req;

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    idx   = sum[IDX_W-1:0];
    grant = any_valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte requesters with
// round-robin grants, one byte per grant, guarded by a watchdog.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : uart_tx_arbiter_if.master (requester handshake, uart_tx
//              drive/feedback, grant_id, arb_busy, timeout_err, state)
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  uart_tx_arbiter_if.master  bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int WD_W  = wd_width(TIMEOUT_CYCLES);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               terr_q, terr_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_byte;
  logic [IDX_W-1:0]   ptr_adv;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_byte = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next round starts just after the requester that was last served.
  assign ptr_adv = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    ready_d = '0;
    done_d  = '0;
    start_d = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !bus.tx_busy) begin
          data_d  = pick_byte;
          grant_d = pick_idx;
          ready_d = pick_grant;
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done is checked first so it wins over a coincident timeout.
        if (bus.tx_done) begin
          done_d  = NUM_REQ'(1) << grant_q;
          ptr_d   = ptr_adv;
          state_d = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          done_d  = NUM_REQ'(1) << grant_q;
          ptr_d   = ptr_adv;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wd_q    <= '0;
      ready_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      start_q <= start_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.req_done      = done_q;
  assign bus.start_trigger = start_q;
  assign bus.tx_data       = data_q;
  assign bus.grant_id      = grant_q;
  assign bus.arb_busy      = (state_q != IDLE);
  assign bus.timeout_err   = terr_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter. Instance a uses
// the default watchdog limit; instance b uses a 64-cycle limit.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter_if #(.NUM_REQ(2), .DATA_W(8)) ia ();
  uart_tx_arbiter_if #(.NUM_REQ(2), .DATA_W(8)) ib ();

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYCLES(64)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ia.req_valid = '0; ia.req_data = '0; ia.tx_busy = 1'b0; ia.tx_done = 1'b0;
    ib.req_valid = '0; ib.req_data = '0; ib.tx_busy = 1'b0; ib.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready_a(input int budget, output logic [1:0] got);
    got = '0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (ia.req_ready != '0) begin
        got = ia.req_ready;
        break;
      end
    end
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL tb_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] got;
    logic [1:0] exp_g;
    logic       bad;
    int         cnt0, cnt1, lat;

    idle_inputs();
    step();
    step();

    // Reset state
    chk("rst_ready", ia.req_ready, 2'b00);
    chk("rst_done", ia.req_done, 2'b00);
    chk("rst_start", ia.start_trigger, 1'b0);
    chk("rst_txdata", ia.tx_data, 8'h00);
    chk("rst_grant", ia.grant_id, 1'b0);
    chk("rst_busy", ia.arb_busy, 1'b0);
    chk("rst_terr", ia.timeout_err, 1'b0);
    chk("rst_state", 32'(ia.state), 32'(IDLE));
    rst = 1'b0;

    // Single request
    ia.req_data  = 16'h0041;
    ia.req_valid = 2'b01;
    step();
    chk("t1_ready", ia.req_ready, 2'b01);
    chk("t1_start_early", ia.start_trigger, 1'b0);
    chk("t1_grant", ia.grant_id, 1'b0);
    ia.req_valid = 2'b00;
    step();
    chk("t1_start", ia.start_trigger, 1'b1);
    chk("t1_txdata", ia.tx_data, 8'h41);
    chk("t1_busy", ia.arb_busy, 1'b1);
    ia.tx_busy = 1'b1;
    bad = 1'b0;
    for (int c = 1; c < 100; c++) begin
      step();
      if (ia.req_done != '0 || ia.start_trigger != 1'b0) bad = 1'b1;
    end
    chk("t1_quiet", bad, 1'b0);
    ia.tx_done = 1'b1;
    ia.tx_busy = 1'b0;
    step();
    ia.tx_done = 1'b0;
    chk("t1_done", ia.req_done, 2'b01);
    chk("t1_terr", ia.timeout_err, 1'b0);
    chk("t1_state", 32'(ia.state), 32'(IDLE));
    step();
    chk("t1_done_pulse", ia.req_done, 2'b00);

    // Contention: both held, alternate grants
    do_reset();
    ia.req_data  = 16'h3231;
    ia.req_valid = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int f = 0; f < 4; f++) begin
      exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready_a(10, got);
      chk("t2_ready", got, exp_g);
      if (got[0]) cnt0++;
      if (got[1]) cnt1++;
      step();
      chk("t2_start", ia.start_trigger, 1'b1);
      chk("t2_txdata", ia.tx_data, (f % 2 == 0) ? 8'h31 : 8'h32);
      ia.tx_busy = 1'b1;
      repeat (5) step();
      ia.tx_done = 1'b1;
      ia.tx_busy = 1'b0;
      step();
      ia.tx_done = 1'b0;
      chk("t2_done", ia.req_done, exp_g);
    end
    chk("t2_count0", cnt0, 2);
    chk("t2_count1", cnt1, 2);
    ia.req_valid = 2'b00;

    // Busy hold-off
    ia.req_data  = 16'h5500;
    ia.tx_busy   = 1'b1;
    ia.req_valid = 2'b10;
    bad = 1'b0;
    repeat (50) begin
      step();
      if (ia.req_ready != '0) bad = 1'b1;
    end
    chk("t3_holdoff", bad, 1'b0);
    ia.tx_busy = 1'b0;
    step();
    chk("t3_ready", ia.req_ready, 2'b10);
    chk("t3_grant", ia.grant_id, 1'b1);
    ia.req_valid = 2'b00;
    step();
    chk("t3_txdata", ia.tx_data, 8'h55);
    ia.tx_done = 1'b1;
    step();
    ia.tx_done = 1'b0;
    chk("t3_done", ia.req_done, 2'b10);

    // Reset mid-frame: move pointer to 1, then reset during WAIT_DONE
    ia.req_data  = 16'h0077;
    ia.req_valid = 2'b01;
    step();
    chk("t6_ready0", ia.req_ready, 2'b01);
    ia.req_valid = 2'b00;
    step();
    ia.tx_done = 1'b1;
    step();
    ia.tx_done = 1'b0;
    ia.req_data  = 16'h6600;
    ia.req_valid = 2'b10;
    step();
    chk("t6_ready1", ia.req_ready, 2'b10);
    ia.req_valid = 2'b00;
    step();
    step();
    chk("t6_mid_state", 32'(ia.state), 32'(WAIT_DONE));
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_start", ia.start_trigger, 1'b0);
    chk("t6_rst_txdata", ia.tx_data, 8'h00);
    chk("t6_rst_grant", ia.grant_id, 1'b0);
    chk("t6_rst_busy", ia.arb_busy, 1'b0);
    chk("t6_rst_ready", ia.req_ready, 2'b00);
    chk("t6_rst_state", 32'(ia.state), 32'(IDLE));
    step();
    rst = 1'b0;
    ia.req_data  = 16'h2211;
    ia.req_valid = 2'b11;
    step();
    chk("t6_next_grant", ia.req_ready, 2'b01);
    ia.req_valid = 2'b00;
    step();
    chk("t6_txdata", ia.tx_data, 8'h11);
    ia.tx_done = 1'b1;
    step();
    ia.tx_done = 1'b0;

    // Timeout on instance b
    ib.req_data  = 16'h0099;
    ib.req_valid = 2'b01;
    step();
    chk("t4_ready", ib.req_ready, 2'b01);
    ib.req_valid = 2'b00;
    step();
    chk("t4_start", ib.start_trigger, 1'b1);
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (ib.req_done != '0) begin
        lat = c;
        break;
      end
    end
    chk("t4_latency", lat, 64);
    chk("t4_done", ib.req_done, 2'b01);
    chk("t4_terr", ib.timeout_err, 1'b1);
    ib.req_data  = 16'hbbaa;
    ib.req_valid = 2'b11;
    step();
    chk("t4_next_grant", ib.req_ready, 2'b10);
    ib.req_valid = 2'b00;
    step();
    chk("t4_txdata", ib.tx_data, 8'hbb);
    ib.tx_done = 1'b1;
    step();
    ib.tx_done = 1'b0;
    chk("t4_done2", ib.req_done, 2'b10);
    repeat (3) step();
    chk("t4_sticky", ib.timeout_err, 1'b1);

    // Same-cycle tx_done and timeout on instance b
    do_reset();
    chk("t5_rst_terr", ib.timeout_err, 1'b0);
    ib.req_data  = 16'h00cc;
    ib.req_valid = 2'b01;
    step();
    chk("t5_ready", ib.req_ready, 2'b01);
    ib.req_valid = 2'b00;
    step();
    chk("t5_start", ib.start_trigger, 1'b1);
    bad = 1'b0;
    repeat (63) begin
      step();
      if (ib.req_done != '0) bad = 1'b1;
    end
    chk("t5_quiet", bad, 1'b0);
    ib.tx_done = 1'b1;
    step();
    ib.tx_done = 1'b0;
    chk("t5_done", ib.req_done, 2'b01);
    chk("t5_terr", ib.timeout_err, 1'b0);
    step();
    chk("t5_done_pulse", ib.req_done, 2'b00);
    repeat (3) step();
    chk("t5_terr_later", ib.timeout_err, 1'b0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
